matrix_skew_feeder: RTL and testbench



---
 rtl/matrix_skew_feeder.sv | 138 +++++++++++++
 tb/tb_matrix_skew_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_skew_feeder.sv
// Skews an N x N operand pair into a systolic array: lane i of each stream is delayed
// by i shifts through triangular delay lines, then flushed with zeros for N-1 cycles.
module matrix_skew_feeder #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  output logic [N*W-1:0] data1,
  output logic [N*W-1:0] data2,
  output logic           out_valid,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW      = $clog2(2 * N);
  localparam int unsigned LANE_BW = N * W;
  localparam int unsigned TRI_BW  = (N * (N - 1) / 2) * W;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TRI_BW-1:0]   line_a_q, line_a_d;
  logic [TRI_BW-1:0]   line_b_q, line_b_d;
  logic [LANE_BW-1:0]  data1_q, data1_d;
  logic [LANE_BW-1:0]  data2_q, data2_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                shift_c;
  logic                clear_c;
  logic [LANE_BW-1:0]  head_a_c;
  logic [LANE_BW-1:0]  head_b_c;

  // Sequencing: beat counter doubles as shift index t (0..2N-2).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_c  = 1'b0;
    clear_c  = 1'b0;
    head_a_c = '0;
    head_b_c = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          shift_c  = 1'b1;
          head_a_c = in_a;
          head_b_c = in_b;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        shift_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * N - 2)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane i owns i registers starting at element offset i*(i-1)/2; lane 0 is a wire-through.
  always_comb begin
    line_a_d = line_a_q;
    line_b_d = line_b_q;
    data1_d  = '0;
    data2_d  = '0;
    if (clear_c) begin
      line_a_d = '0;
      line_b_d = '0;
    end else if (shift_c) begin
      data1_d[0 +: W] = head_a_c[0 +: W];
      data2_d[0 +: W] = head_b_c[0 +: W];
      for (int unsigned i = 1; i < N; i++) begin
        data1_d[i*W +: W] = line_a_q[((i * (i - 1) / 2) + i - 1) * W +: W];
        data2_d[i*W +: W] = line_b_q[((i * (i - 1) / 2) + i - 1) * W +: W];
        line_a_d[(i * (i - 1) / 2) * W +: W] = head_a_c[i*W +: W];
        line_b_d[(i * (i - 1) / 2) * W +: W] = head_b_c[i*W +: W];
        for (int unsigned k = 1; k < i; k++) begin
          line_a_d[((i * (i - 1) / 2) + k) * W +: W] = line_a_q[((i * (i - 1) / 2) + k - 1) * W +: W];
          line_b_d[((i * (i - 1) / 2) + k) * W +: W] = line_b_q[((i * (i - 1) / 2) + k - 1) * W +: W];
        end
      end
    end
  end

  always_comb begin
    out_valid_d = shift_c;
    done_d      = (state_q == FLUSH) && (cnt_q == CW'(2 * N - 2));
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_a_q    <= '0;
      line_b_q    <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_a_q    <= line_a_d;
      line_b_q    <= line_b_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Scoreboard bench for matrix_skew_feeder: stimulus queues expected skew beats,
// a negedge monitor pops and compares every beat and checks zeros between beats.
module tb_matrix_skew_feeder;

  localparam int unsigned N  = 32;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = N * W;
  localparam int unsigned NB = 2 * N - 1;

  typedef struct packed {
    logic [NW-1:0] d1;
    logic [NW-1:0] d2;
    logic          dn;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_a;
  logic [NW-1:0] in_b;
  logic [NW-1:0] data1;
  logic [NW-1:0] data2;
  logic          out_valid;
  logic          busy;
  logic          done;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_cmp    = 0;
  int    n_bad    = 0;
  int    cur_pat  = 0;
  int    beat_idx = 0;
  int    done_cnt = 0;

  matrix_skew_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .data1(data1), .data2(data2),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] elem_a(input int pat, input int i, input int k);
    case (pat)
      0:       return W'(i + k);
      1:       return 8'h80;
      default: return W'(i * 3 + k * 5 + 1);
    endcase
  endfunction

  function automatic logic [W-1:0] elem_b(input int pat, input int k, input int j);
    case (pat)
      0:       return W'(k - j);
      1:       return 8'h7F;
      default: return W'((k * 7) ^ (j * 11) ^ 85);
    endcase
  endfunction

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_run(input int pat);
    beat_t b;
    for (int t = 0; t < int'(NB); t++) begin
      b = '0;
      for (int i = 0; i < int'(N); i++) begin
        if (t - i >= 0 && t - i < int'(N)) begin
          b.d1[i*W +: W] = elem_a(pat, i, t - i);
          b.d2[i*W +: W] = elem_b(pat, t - i, i);
        end
      end
      b.dn = (t == int'(NB) - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_vec(input int pat, input int k);
    for (int i = 0; i < int'(N); i++) begin
      in_a[i*W +: W] = elem_a(pat, i, k);
      in_b[i*W +: W] = elem_b(pat, k, i);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain;
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    check("idle_busy", NW'(busy), NW'(0));
    check("idle_in_ready", NW'(in_ready), NW'(0));
  endtask

  task automatic run(input int pat, input bit gaps, input bit start_glitch);
    cur_pat = pat;
    push_run(pat);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_in_ready", NW'(in_ready), NW'(1));
    check("load_busy", NW'(busy), NW'(1));
    for (int k = 0; k < int'(N); k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
        check("gap_in_ready", NW'(in_ready), NW'(1));
      end
      if (start_glitch && k == 5) start = 1'b1;
      drive_vec(pat, k);
      in_valid = 1'b1;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    if (start_glitch) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_drain();
  endtask

  // Monitor: compare each presented beat against the queue head.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got out_valid=1 expected no beat at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("data1", data1, mon_e.d1);
        check("data2", data2, mon_e.d2);
        check("done", NW'(done), NW'(mon_e.dn));
        if (cur_pat == 0 && beat_idx == 0) check("p0_beat0_data1", data1, '0);
        if (cur_pat == 0 && beat_idx == 31) check("p0_beat31_lane31", NW'(data1[31*W +: W]), NW'(8'd31));
        if (cur_pat == 1 && beat_idx == 0) begin
          check("p1_beat0_lane0_a", NW'(data1[0 +: W]), NW'(8'h80));
          check("p1_beat0_lane0_b", NW'(data2[0 +: W]), NW'(8'h7F));
        end
        if (done) begin
          done_cnt++;
          check("beats_per_run", NW'(beat_idx + 1), NW'(NB));
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
    end else begin
      check("gap_data1", data1, '0);
      check("gap_data2", data2, '0);
      check("gap_done", NW'(done), NW'(0));
    end
    if (!rst) beat_idx = 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #12;
    check("rst_data1", data1, '0);
    check("rst_data2", data2, '0);
    check("rst_out_valid", NW'(out_valid), NW'(0));
    check("rst_busy", NW'(busy), NW'(0));
    check("rst_done", NW'(done), NW'(0));
    check("rst_in_ready", NW'(in_ready), NW'(0));
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", NW'(in_ready), NW'(0));

    run(0, 1'b0, 1'b0);
    run(0, 1'b1, 1'b1);
    run(1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0);

    // Abort mid-LOAD after 10 accepted vectors.
    cur_pat = 0;
    push_run(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_vec(0, k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("abort_pending", NW'(exp_q.size()), NW'(NB - 10));
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("abort_data1", data1, '0);
    check("abort_data2", data2, '0);
    check("abort_out_valid", NW'(out_valid), NW'(0));
    check("abort_busy", NW'(busy), NW'(0));
    check("abort_in_ready", NW'(in_ready), NW'(0));
    tick();
    tick();
    rst = 1'b1;
    drive_vec(0, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("nostart_in_ready", NW'(in_ready), NW'(0));
      check("nostart_busy", NW'(busy), NW'(0));
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("total_done_pulses", NW'(done_cnt), NW'(5));
    check("queue_empty", NW'(exp_q.size()), NW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
